// File: rtl/mips_core_pkg.sv
// Shared core types for the cache refill path: arbiter state/owner enums and line geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_XFER
    } arb_state_e;

    typedef enum logic {
        OWNER_IC,
        OWNER_DC
    } arb_owner_e;

    // Beats per cache line; the caches size their line buffers from this too.
    localparam int CACHE_LINE_WORDS = 4;

endpackage

// File: rtl/refill_arb_priority.sv
// Picks which cache owns the next memory burst; DC first unless IC has been starved.
// Latency: winner is combinational; starvation count updates on the accept edge.
// Backpressure: none; the caller decides when a grant is taken via accept.
module refill_arb_priority
    import mips_core_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ic_valid,
    input  logic       dc_valid,
    input  logic       accept,
    output arb_owner_e winner
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             ic_starved;

    always_comb begin
        ic_starved = ic_valid && (starve_cnt == CNT_MAX);
        winner     = (dc_valid && !ic_starved) ? OWNER_DC : OWNER_IC;
    end

    // Only DC wins that actually made IC wait count toward starvation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (accept) begin
            if (winner == OWNER_IC) begin
                starve_cnt <= '0;
            end else if (ic_valid && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/writebacks, one line at a time.
// Latency: grant same cycle as request, command the cycle after, then LINE_WORDS data beats.
// Backpressure: memory stalls via cmd_ready/wready/rvalid; requests wait (valid held) while busy.
module cache_refill_arbiter
    import mips_core_pkg::*;
#(
    parameter int ADDR_W       = 26,
    parameter int DATA_W       = 32,
    parameter int LINE_WORDS   = CACHE_LINE_WORDS,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req_valid,
    input  logic              dc_req_we,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic              mem_cmd_valid,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    input  logic              mem_cmd_ready,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              protocol_err
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef struct packed {
        arb_owner_e        owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
    } line_req_t;

    arb_state_e        state, state_nxt;
    line_req_t         req_q;
    logic [BEAT_W-1:0] beat_cnt;
    arb_owner_e        winner;
    logic              accept;
    logic              rd_xfer;
    logic              wr_xfer;
    logic              beat;
    logic              last_beat;

    // Grants are masked during reset so every output reads 0 while rst is high.
    assign accept    = (state == ARB_IDLE) && (ic_req_valid || dc_req_valid) && !rst;
    assign rd_xfer   = (state == ARB_XFER) && !req_q.we;
    assign wr_xfer   = (state == ARB_XFER) && req_q.we;
    assign beat      = (rd_xfer && mem_rvalid) || (wr_xfer && mem_wready);
    assign last_beat = beat && (beat_cnt == LAST_BEAT);
    assign busy      = (state != ARB_IDLE);

    refill_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .ic_valid(ic_req_valid),
        .dc_valid(dc_req_valid),
        .accept  (accept),
        .winner  (winner)
    );

    always_comb begin
        state_nxt     = state;
        ic_req_ready  = 1'b0;
        dc_req_ready  = 1'b0;
        ic_rdata      = '0;
        ic_rvalid     = 1'b0;
        ic_done       = 1'b0;
        dc_rdata      = '0;
        dc_rvalid     = 1'b0;
        dc_done       = 1'b0;
        dc_wready     = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_wdata     = '0;
        mem_wvalid    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (accept) begin
                    ic_req_ready = (winner == OWNER_IC);
                    dc_req_ready = (winner == OWNER_DC);
                    state_nxt    = ARB_CMD;
                end
            end
            ARB_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = req_q.we;
                mem_cmd_addr  = req_q.addr;
                if (mem_cmd_ready) begin
                    state_nxt = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (req_q.we) begin
                    mem_wvalid = 1'b1;
                    mem_wdata  = dc_wdata;
                    dc_wready  = mem_wready;
                    dc_done    = last_beat;
                end else if (req_q.owner == OWNER_IC) begin
                    ic_rvalid = mem_rvalid;
                    ic_rdata  = mem_rdata;
                    ic_done   = last_beat;
                end else begin
                    dc_rvalid = mem_rvalid;
                    dc_rdata  = mem_rdata;
                    dc_done   = last_beat;
                end
                if (last_beat) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ARB_IDLE;
            req_q        <= '0;
            beat_cnt     <= '0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q.owner <= winner;
                req_q.we    <= (winner == OWNER_DC) && dc_req_we;
                req_q.addr  <= (winner == OWNER_DC) ? dc_req_addr : ic_req_addr;
            end
            // LINE_WORDS is a power of two, so the counter wraps to 0 on the last beat.
            if ((state == ARB_CMD) && mem_cmd_ready) begin
                beat_cnt <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if ((mem_rvalid && !rd_xfer) || (mem_wready && !wr_xfer)) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: directed refills/writebacks against a scripted memory,
// expected events queued by the stimulus and popped by an independent monitor.
module tb_cache_refill_arbiter;

    localparam logic [3:0] K_ACKI = 4'd1;
    localparam logic [3:0] K_ACKD = 4'd2;
    localparam logic [3:0] K_CMD  = 4'd3;
    localparam logic [3:0] K_IR   = 4'd4;
    localparam logic [3:0] K_DR   = 4'd5;
    localparam logic [3:0] K_W    = 4'd6;

    typedef struct packed {
        logic [3:0]  kind;
        logic        done;
        logic [31:0] dat;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req_valid;
    logic [25:0] ic_req_addr;
    logic        ic_req_ready;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic        ic_done;
    logic        dc_req_valid;
    logic        dc_req_we;
    logic [25:0] dc_req_addr;
    logic        dc_req_ready;
    logic [31:0] dc_wdata;
    logic        dc_wready;
    logic [31:0] dc_rdata;
    logic        dc_rvalid;
    logic        dc_done;
    logic        mem_cmd_valid;
    logic        mem_cmd_we;
    logic [25:0] mem_cmd_addr;
    logic        mem_cmd_ready;
    logic [31:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;
    logic        protocol_err;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ack_cyc = 0;
    int          ack_ic_cyc = 0;
    int          dc_done_cyc = 0;
    int          ic_reqs = 0;
    int          ic_acks = 0;
    int          dc_reqs = 0;
    int          dc_acks = 0;
    bit          ic_acc, dc_acc, w_acc, cmd_prev;
    bit          cmd_seen, hs_we, rd_active, wtog;
    bit          inj_rvalid = 1'b0;
    int          rd_i, w_i;
    logic [31:0] rd_base = '0;
    logic [31:0] wr_mul = '0;

    always #5 clk = ~clk;

    cache_refill_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .ic_req_valid (ic_req_valid),
        .ic_req_addr  (ic_req_addr),
        .ic_req_ready (ic_req_ready),
        .ic_rdata     (ic_rdata),
        .ic_rvalid    (ic_rvalid),
        .ic_done      (ic_done),
        .dc_req_valid (dc_req_valid),
        .dc_req_we    (dc_req_we),
        .dc_req_addr  (dc_req_addr),
        .dc_req_ready (dc_req_ready),
        .dc_wdata     (dc_wdata),
        .dc_wready    (dc_wready),
        .dc_rdata     (dc_rdata),
        .dc_rvalid    (dc_rvalid),
        .dc_done      (dc_done),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_we   (mem_cmd_we),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_wdata    (mem_wdata),
        .mem_wvalid   (mem_wvalid),
        .mem_wready   (mem_wready),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic push_ev(input logic [3:0] k, input logic d, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.done = d;
        e.dat  = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_rd(input bit is_dc, input logic [25:0] a, input logic [31:0] base);
        push_ev(is_dc ? K_ACKD : K_ACKI, 1'b0, 32'h0);
        push_ev(K_CMD, 1'b0, {1'b0, 5'd0, a});
        for (int i = 0; i < 4; i++)
            push_ev(is_dc ? K_DR : K_IR, (i == 3), base + 32'(i));
    endtask

    task automatic exp_wr(input logic [25:0] a, input logic [31:0] mul);
        push_ev(K_ACKD, 1'b0, 32'h0);
        push_ev(K_CMD, 1'b0, {1'b1, 5'd0, a});
        for (int i = 0; i < 4; i++)
            push_ev(K_W, (i == 3), mul * 32'(i + 1));
    endtask

    task automatic sb(input logic [3:0] k, input logic d, input logic [31:0] v);
        ev_t g, e;
        g.kind = k;
        g.done = d;
        g.dat  = v;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got kind=%0d done=%0b dat=%h, required no event", k, d, v);
        end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
                bad++;
                $display("FAIL sb_event: got kind=%0d done=%0b dat=%h, required kind=%0d done=%0b dat=%h",
                         g.kind, g.done, g.dat, e.kind, e.done, e.dat);
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(exp_q.size() == 0 && !busy) && n < 400);
        if (!(exp_q.size() == 0 && !busy)) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending events busy=%0b, required 0 pending and idle",
                     nm, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    // Requesters and scripted memory: cmd_ready one cycle after cmd_valid, 4 read beats,
    // write beats accepted every other cycle.
    initial begin
        ic_req_valid  = 1'b0;
        dc_req_valid  = 1'b0;
        mem_cmd_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        mem_wready    = 1'b0;
        dc_wdata      = '0;
        cmd_seen = 0; hs_we = 0; rd_active = 0; wtog = 0; rd_i = 0; w_i = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ic_acc) ic_acks++;
            if (dc_acc) dc_acks++;
            ic_req_valid = (ic_acks != ic_reqs);
            dc_req_valid = (dc_acks != dc_reqs);
            if (rst) begin
                mem_cmd_ready = 1'b0;
                mem_rvalid = 1'b0;
                mem_rdata = '0;
                mem_wready = 1'b0;
                cmd_seen = 0; rd_active = 0; rd_i = 0; wtog = 0; w_i = 0;
            end else begin
                if (mem_cmd_ready) begin
                    mem_cmd_ready = 1'b0;
                    cmd_seen = 0;
                    rd_active = !hs_we;
                    rd_i = 0;
                end else if (mem_cmd_valid) begin
                    if (cmd_seen) begin
                        mem_cmd_ready = 1'b1;
                        hs_we = mem_cmd_we;
                    end else begin
                        cmd_seen = 1;
                    end
                end
                if (rd_active && rd_i < 4) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd_base + 32'(rd_i);
                    rd_i++;
                end else begin
                    rd_active = 0;
                    mem_rvalid = inj_rvalid;
                    mem_rdata = inj_rvalid ? 32'hDEAD_BEEF : 32'h0;
                end
                if (w_acc) w_i++;
                if (mem_wvalid) begin
                    mem_wready = wtog;
                    wtog = !wtog;
                end else begin
                    mem_wready = 1'b0;
                    wtog = 0;
                    w_i = 0;
                end
            end
            dc_wdata = wr_mul * 32'(w_i + 1);
        end
    end

    // Monitor: every visible transfer is popped against the expected queue.
    initial begin
        cmd_prev = 0; ic_acc = 0; dc_acc = 0; w_acc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            ic_acc = ic_req_ready;
            dc_acc = dc_req_ready;
            w_acc  = dc_wready;
            if (rst) begin
                cmd_prev = 0;
            end else begin
                if (ic_req_ready) begin
                    sb(K_ACKI, 1'b0, 32'h0);
                    ack_cyc = cyc;
                    ack_ic_cyc = cyc;
                end
                if (dc_req_ready) begin
                    sb(K_ACKD, 1'b0, 32'h0);
                    ack_cyc = cyc;
                end
                if (mem_cmd_valid && !cmd_prev)
                    cmp("cmd_latency", 32'(cyc - ack_cyc), 32'd1);
                cmd_prev = mem_cmd_valid;
                if (mem_cmd_valid && mem_cmd_ready)
                    sb(K_CMD, 1'b0, {mem_cmd_we, 5'd0, mem_cmd_addr});
                if (ic_rvalid) sb(K_IR, ic_done, ic_rdata);
                if (dc_rvalid) sb(K_DR, dc_done, dc_rdata);
                if (mem_wvalid && mem_wready) sb(K_W, dc_done, mem_wdata);
                if (dc_done) dc_done_cyc = cyc;
                cmp("dc_wready", {31'd0, dc_wready}, {31'd0, mem_wvalid && mem_wready});
                cmp("stray_done", {31'd0, (ic_done && !ic_rvalid) ||
                    (dc_done && !dc_rvalid && !(mem_wvalid && mem_wready))}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ic_req_addr = '0;
        dc_req_we = 1'b0;
        dc_req_addr = '0;
        #1;
        cmp("rst_ctrl", {20'd0, ic_req_ready, ic_rvalid, ic_done, dc_req_ready, dc_wready, dc_rvalid,
                         dc_done, mem_cmd_valid, mem_cmd_we, mem_wvalid, busy, protocol_err}, 32'd0);
        cmp("rst_data", ic_rdata | dc_rdata | mem_wdata | {6'd0, mem_cmd_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        cmp("idle_busy", {31'd0, busy}, 32'd0);
        cmp("idle_starve", 32'(dut.u_prio.starve_cnt), 32'd0);

        // Single I-cache refill
        ic_req_addr = 26'h100;
        rd_base = 32'hA0;
        exp_rd(1'b0, 26'h100, 32'hA0);
        ic_reqs++;
        wait_idle("ic_refill");

        // Simultaneous requests: DC first, IC granted in the IDLE cycle right after dc_done
        ic_req_addr = 26'h140;
        dc_req_addr = 26'h200;
        rd_base = 32'h60;
        exp_rd(1'b1, 26'h200, 32'h60);
        exp_rd(1'b0, 26'h140, 32'h60);
        ic_reqs++;
        dc_reqs++;
        wait_idle("simul");
        cmp("grant_gap", 32'(ack_ic_cyc - dc_done_cyc), 32'd1);

        // Starvation: three DC wins, then IC forced, then the last DC request
        ic_req_addr = 26'h2C0;
        dc_req_addr = 26'h280;
        rd_base = 32'h50;
        for (int i = 0; i < 3; i++) exp_rd(1'b1, 26'h280, 32'h50);
        exp_rd(1'b0, 26'h2C0, 32'h50);
        exp_rd(1'b1, 26'h280, 32'h50);
        ic_reqs++;
        dc_reqs += 4;
        wait_idle("starve");
        cmp("starve_cleared", 32'(dut.u_prio.starve_cnt), 32'd0);

        // D-cache writeback with memory accepting every other cycle
        dc_req_we = 1'b1;
        dc_req_addr = 26'h300;
        wr_mul = 32'h11;
        exp_wr(26'h300, 32'h11);
        dc_reqs++;
        wait_idle("writeback");
        dc_req_we = 1'b0;
        cmp("perr_clean", {31'd0, protocol_err}, 32'd0);

        // Reset after two of four read beats
        ic_req_addr = 26'h1C0;
        rd_base = 32'hB0;
        push_ev(K_ACKI, 1'b0, 32'h0);
        push_ev(K_CMD, 1'b0, {6'd0, 26'h1C0});
        push_ev(K_IR, 1'b0, 32'hB0);
        push_ev(K_IR, 1'b0, 32'hB1);
        ic_reqs++;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (exp_q.size() != 0 && n < 100);
        end
        cmp("mid_pending", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        cmp("mid_rst_ctrl", {20'd0, ic_req_ready, ic_rvalid, ic_done, dc_req_ready, dc_wready, dc_rvalid,
                             dc_done, mem_cmd_valid, mem_cmd_we, mem_wvalid, busy, protocol_err}, 32'd0);
        cmp("mid_rst_data", ic_rdata | dc_rdata | mem_wdata | {6'd0, mem_cmd_addr}, 32'd0);
        exp_q.delete();
        ic_req_addr = 26'h180;
        rd_base = 32'hC0;
        exp_rd(1'b0, 26'h180, 32'hC0);
        ic_reqs++;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        cmp("ack_after_rst", {31'd0, ic_req_ready}, 32'd1);
        wait_idle("after_rst");

        // Stray read beat while IDLE: ignored for routing, sticky error
        cmp("perr_before", {31'd0, protocol_err}, 32'd0);
        @(negedge clk);
        inj_rvalid = 1'b1;
        @(negedge clk);
        inj_rvalid = 1'b0;
        @(negedge clk);
        cmp("perr_set", {31'd0, protocol_err}, 32'd1);
        repeat (5) @(negedge clk);
        cmp("perr_sticky", {31'd0, protocol_err}, 32'd1);
        cmp("perr_no_route", 32'(exp_q.size()), 32'd0);
        #1 rst = 1'b1;
        #1;
        cmp("perr_rst", {31'd0, protocol_err}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
